key_schedule_ctrl: RTL and testbench
====================================

Name: key_schedule_ctrl

Overview:
- Sequencer for the byte-serial key register unit (16 x 8-bit shift registers, 2-byte subkey port).
- Drives en, dochoosesboxin, key_reg_move, dofirstsubkey, dokeyfirstcol, dokeyothercol, doxorRcon and Rcon to load a 128-bit key, emit round-0 key, then emit round keys 1..NR at 2 bytes/cycle.
- Shares the single S-box with the state datapath through a req/gnt handshake.

Parameters:
- NR, 10, number of expanded round keys after round 0.
- LOAD_CYCLES, 16, key load cycles, one byte per cycle.
- SBOX_LAT, 1, cycles from keytosbox to valid S-box result at keyin.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  begin load and expansion; accepted only in IDLE.
- hold  in  1  consumer stall; freezes sequencing.
- sbox_gnt  in  1  arbiter grants the S-box to the key path.
- sbox_req  out  1  key path requests the S-box.
- key_byte_req  out  1  upstream must present the next key byte on keyin[7:0]; equals en.
- en, dochoosesboxin, key_reg_move, dofirstsubkey, dokeyfirstcol, dokeyothercol, doxorRcon  out  1 each  key register unit strobes.
- Rcon  out  8  round constant.
- subkey_valid  out  1  subkey port carries 2 valid bytes this cycle.
- subkey_last  out  1  final 2 bytes of the final round key.
- round_idx  out  4  round of the current subkey, 0..NR.
- busy  out  1  not IDLE.
- done  out  1  one-cycle pulse after the last subkey.

Behaviour:
- Reset, applied in any state including mid-round: state=IDLE, counters 0, Rcon=8'h01, round_idx=0, done=0. All strobes, sbox_req, subkey_valid and busy are 0.
- Outputs are Moore decodes of the registered state and counters. Rcon, round_idx and done are registered.
- IDLE: busy=0. start=1 moves to LOAD next cycle and sets Rcon=8'h01 and round_idx=0. start outside IDLE is ignored.
- LOAD:
  - en=1 and key_byte_req=1 for LOAD_CYCLES consecutive cycles; hold is ignored.
  - After the last cycle, go to FIRST.
- FIRST:
  - 8 counted cycles, c=0..7: dofirstsubkey=1, key_reg_move=1, subkey_valid=1, round_idx=0.
  - After c=7, go to REQ.
- REQ: sbox_req=1 and no other strobes. Stay until sbox_gnt=1, then go to PREP.
- PREP:
  - sbox_req stays 1 through PREP and WAIT.
  - Cycle p0 presents keytosbox with no strobes.
  - Cycle p1 asserts dochoosesboxin=1.
  - Go to WAIT.
- WAIT:
  - Hold SBOX_LAT cycles with no strobes; the unit registers the S-box output internally.
  - Then go to ROUND.
- ROUND:
  - 8 counted cycles, c=0..7: key_reg_move=1 and subkey_valid=1 on every counted cycle.
  - dokeyfirstcol=1 for c in {0,1}; dokeyothercol=1 for c in 2..7; doxorRcon=1 at c=0 only.
  - sbox_req drops at entry.
  - At c=7: Rcon <= xtime(Rcon), i.e. (Rcon<<1) ^ (Rcon[7] ? 8'h1B : 0), and round_idx increments.
  - If round_idx==NR, go to DONE; otherwise go to REQ.
  - The Rcon sequence is 01,02,04,08,10,20,40,80,1B,36. Rcon holds its value outside ROUND c=7.
- DONE: done=1 for one cycle, then IDLE.
- subkey_last=1 at ROUND c=7 of round NR only.
- hold=1 in FIRST or ROUND:
  - All strobes and subkey_valid are forced to 0 and the counter freezes.
  - The same c resumes when hold=0.
  - hold does not affect REQ, PREP or WAIT.
- sbox_gnt deasserting during PREP or WAIT is a protocol error; sequencing continues regardless (assertion in bench).
- Strobe exclusivity: at most one of en, dochoosesboxin, key_reg_move is 1 per cycle. dokeyfirstcol and dokeyothercol are never both 1.
- Throughput with gnt always 1, hold 0, SBOX_LAT=1: 16 + 8 + NR*(1+2+1+8) + 1 = 145 cycles from start acceptance to done.

Decomposition:
- Shared package:
  - FSM state enum IDLE/LOAD/FIRST/REQ/PREP/WAIT/ROUND/DONE.
  - RCON_INIT=8'h01 and RCON_POLY=8'h1B.
  - xtime function, reused by the datapath MixColumns controller.
- One sub-module: rcon_gen (register, init, advance enable, xtime), because the data path's round counter also needs it.

Test Plan:
- Nominal: start, gnt tied 1, hold 0 -> en high cycles 1..16; 88 subkey_valid cycles; done at cycle 145. Bench captures FIPS-197 key 2b7e1516.. and round 10 key d014f9a8c9ee2589e13f0cc8b6630ca6.
- Rcon trace -> doxorRcon cycles show Rcon = 01,02,04,08,10,20,40,80,1B,36; Rcon reads 6C after the final advance.
- Grant delay: sbox_gnt low 5 cycles in each REQ -> sbox_req held, no strobes; total latency 145+50.
- Hold mid-ROUND: hold=1 for 3 cycles at round 4, c=1 -> strobes 0, resumes at c=1 with dokeyfirstcol; key output unchanged.
- Reset mid-op: rst_n=0 during round 6 WAIT -> next cycle IDLE, Rcon=01, all outputs 0; new start completes a correct expansion.
- Start while busy: start pulses in LOAD and ROUND -> ignored, cycle count unchanged.

Source files
------------

// File: rtl/key_schedule_ctrl_pkg.sv
// Shared types and helpers for the key schedule sequencer and its neighbours.
package key_schedule_ctrl_pkg;

  // Sequencer states; REQ/PREP/WAIT cover borrowing the shared S-box.
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FIRST,
    REQ,
    PREP,
    WAIT,
    ROUND,
    DONE
  } ks_state_e;

  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] RCON_POLY = 8'h1B;

  // Wide enough for the longest counted phase (key load, up to 32 cycles).
  localparam int CNT_W = 5;

  // Multiply by x in GF(2^8); also used by the MixColumns controller.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/key_schedule_ctrl_if.sv
// Handshake and strobe bundle between the key schedule sequencer (master)
// and the key register unit / S-box arbiter / upstream key source (slave).
interface key_schedule_ctrl_if;

  logic       start;
  logic       hold;
  logic       sbox_gnt;
  logic       sbox_req;
  logic       key_byte_req;
  logic       en;
  logic       dochoosesboxin;
  logic       key_reg_move;
  logic       dofirstsubkey;
  logic       dokeyfirstcol;
  logic       dokeyothercol;
  logic       doxorRcon;
  logic [7:0] Rcon;
  logic       subkey_valid;
  logic       subkey_last;
  logic [3:0] round_idx;
  logic       busy;
  logic       done;

  modport master (
    input  start, hold, sbox_gnt,
    output sbox_req, key_byte_req, en, dochoosesboxin, key_reg_move,
           dofirstsubkey, dokeyfirstcol, dokeyothercol, doxorRcon, Rcon,
           subkey_valid, subkey_last, round_idx, busy, done
  );

  modport slave (
    output start, hold, sbox_gnt,
    input  sbox_req, key_byte_req, en, dochoosesboxin, key_reg_move,
           dofirstsubkey, dokeyfirstcol, dokeyothercol, doxorRcon, Rcon,
           subkey_valid, subkey_last, round_idx, busy, done
  );

endinterface

// File: rtl/key_schedule_ctrl_rcon_gen.sv
// rcon_gen: round constant register. Reloads to 01 on init and steps by
// xtime on advance; shared with the data path's round counter.
module rcon_gen
  import key_schedule_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       init,
  input  logic       advance,
  output logic [7:0] rcon
);

  // Round constant register: reset/init to 01, otherwise hold or advance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rcon <= RCON_INIT;
    end else if (init) begin
      rcon <= RCON_INIT;
    end else if (advance) begin
      rcon <= xtime(rcon);
    end
  end

endmodule

// File: rtl/key_schedule_ctrl.sv
// key_schedule_ctrl: sequencer for the byte-serial key register unit.
// Loads a 128-bit key one byte per cycle, streams the round-0 key, then for
// each later round borrows the shared S-box and streams the next round key
// two bytes per cycle. hold stalls the streaming phases only.
module key_schedule_ctrl
  import key_schedule_ctrl_pkg::*;
#(
  parameter int NR          = 10,
  parameter int LOAD_CYCLES = 16,
  parameter int SBOX_LAT    = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  key_schedule_ctrl_if.master bus
);

  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(LOAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] COL_LAST  = CNT_W'(7);
  localparam logic [CNT_W-1:0] PREP_LAST = CNT_W'(1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(SBOX_LAT - 1);
  localparam logic [3:0]       NR_IDX    = 4'(NR);

  ks_state_e        state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [3:0]       round_q;
  logic             done_q;
  logic [7:0]       rcon;

  logic stalled;
  logic accept_start;
  logic first_end;
  logic round_end;

  logic sbox_req_c, en_c, dochoosesboxin_c, key_reg_move_c, dofirstsubkey_c;
  logic dokeyfirstcol_c, dokeyothercol_c, doxorRcon_c, subkey_valid_c, subkey_last_c;

  assign stalled      = bus.hold && (state == FIRST || state == ROUND);
  assign accept_start = (state == IDLE) && bus.start;
  assign first_end    = (state == FIRST) && !stalled && (cnt == COL_LAST);
  assign round_end    = (state == ROUND) && !stalled && (cnt == COL_LAST);

  // State and phase counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next state and phase counter; the counter restarts at every phase change
  // and freezes while the streaming phases are stalled.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_next = LOAD;
          cnt_next   = '0;
        end
      end
      LOAD: begin
        if (cnt == LOAD_LAST) begin
          state_next = FIRST;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      FIRST: begin
        if (first_end) begin
          state_next = REQ;
          cnt_next   = '0;
        end else if (!stalled) begin
          cnt_next = cnt + 1'b1;
        end
      end
      REQ: begin
        if (bus.sbox_gnt) begin
          state_next = PREP;
          cnt_next   = '0;
        end
      end
      PREP: begin
        if (cnt == PREP_LAST) begin
          state_next = WAIT;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      WAIT: begin
        if (cnt == WAIT_LAST) begin
          state_next = ROUND;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      ROUND: begin
        if (round_end) begin
          state_next = (round_q == NR_IDX) ? DONE : REQ;
          cnt_next   = '0;
        end else if (!stalled) begin
          cnt_next = cnt + 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Round index (1 from the end of the round-0 key, saturating at NR) and the
  // registered done pulse, which is high exactly while in DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      round_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= (state_next == DONE);
      if (accept_start) begin
        round_q <= '0;
      end else if (first_end) begin
        round_q <= 4'd1;
      end else if (round_end && round_q != NR_IDX) begin
        round_q <= round_q + 4'd1;
      end
    end
  end

  rcon_gen u_rcon (
    .clk     (clk),
    .rst_n   (rst_n),
    .init    (accept_start),
    .advance (round_end),
    .rcon    (rcon)
  );

  // Strobe decode from state and counter; a stall blanks the streaming strobes.
  always_comb begin
    sbox_req_c       = 1'b0;
    en_c             = 1'b0;
    dochoosesboxin_c = 1'b0;
    key_reg_move_c   = 1'b0;
    dofirstsubkey_c  = 1'b0;
    dokeyfirstcol_c  = 1'b0;
    dokeyothercol_c  = 1'b0;
    doxorRcon_c      = 1'b0;
    subkey_valid_c   = 1'b0;
    subkey_last_c    = 1'b0;
    case (state)
      LOAD: en_c = 1'b1;
      FIRST: begin
        if (!stalled) begin
          dofirstsubkey_c = 1'b1;
          key_reg_move_c  = 1'b1;
          subkey_valid_c  = 1'b1;
        end
      end
      REQ:  sbox_req_c = 1'b1;
      PREP: begin
        sbox_req_c       = 1'b1;
        dochoosesboxin_c = (cnt == PREP_LAST);
      end
      WAIT: sbox_req_c = 1'b1;
      ROUND: begin
        if (!stalled) begin
          key_reg_move_c  = 1'b1;
          subkey_valid_c  = 1'b1;
          dokeyfirstcol_c = (cnt < CNT_W'(2));
          dokeyothercol_c = (cnt >= CNT_W'(2));
          doxorRcon_c     = (cnt == '0);
          subkey_last_c   = (cnt == COL_LAST) && (round_q == NR_IDX);
        end
      end
      default: begin
      end
    endcase
  end

  assign bus.sbox_req       = sbox_req_c;
  assign bus.en             = en_c;
  assign bus.key_byte_req   = en_c;
  assign bus.dochoosesboxin = dochoosesboxin_c;
  assign bus.key_reg_move   = key_reg_move_c;
  assign bus.dofirstsubkey  = dofirstsubkey_c;
  assign bus.dokeyfirstcol  = dokeyfirstcol_c;
  assign bus.dokeyothercol  = dokeyothercol_c;
  assign bus.doxorRcon      = doxorRcon_c;
  assign bus.subkey_valid   = subkey_valid_c;
  assign bus.subkey_last    = subkey_last_c;
  assign bus.Rcon           = rcon;
  assign bus.round_idx      = round_q;
  assign bus.busy           = (state != IDLE);
  assign bus.done           = done_q;

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Testbench for key_schedule_ctrl: table of full expansions under different
// grant delays, stalls and stray starts, plus reset sequences.
module tb_key_schedule_ctrl;

  localparam int          MAX_CYCLES = 400;
  localparam logic [79:0] RCON_TRACE = 80'h01020408102040801B36;

  typedef struct {
    int         gnt_delay;
    int         hold_after_k;
    int         hold_len;
    bit         stray_start;
    int         exp_done_cycle;
    int         exp_en;
    int         exp_valid;
    logic [7:0] exp_final_rcon;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;

  int total = 0;
  int bad   = 0;

  int          cyc, k, done_cycle, en_count, first_en, last_en;
  int          pattern_err, excl_err, hold_err, req_err, req_cycles, req_run;
  int          choose_count, last_cycle, final_round, hold_pending;
  logic [79:0] rcon_trace;
  logic [7:0]  final_rcon;
  logic        granted, idle_busy;
  vec_t        vecs[5];

  // Free-running clock.
  always #5 clk = ~clk;

  key_schedule_ctrl_if bus_if ();

  key_schedule_ctrl #(
    .NR          (10),
    .LOAD_CYCLES (16),
    .SBOX_LAT    (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  function automatic logic [10:0] all_outs();
    return {bus_if.en, bus_if.dochoosesboxin, bus_if.key_reg_move, bus_if.dofirstsubkey,
            bus_if.dokeyfirstcol, bus_if.dokeyothercol, bus_if.doxorRcon, bus_if.sbox_req,
            bus_if.subkey_valid, bus_if.subkey_last, bus_if.key_byte_req};
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, actual, actual,
               expected, expected);
    end
  endtask

  task automatic sampleCycle(input vec_t v);
    int r, c;
    assert (!(granted && bus_if.sbox_req && !bus_if.sbox_gnt))
      else begin
        bad++;
        $display("[TB] FAIL gnt_protocol: cycle %0d sbox_gnt got 0 required 1", cyc);
      end
    if (!bus_if.sbox_req) granted = 1'b0;
    else if (bus_if.sbox_gnt) granted = 1'b1;

    if (bus_if.en) begin
      en_count++;
      if (first_en < 0) first_en = cyc;
      last_en = cyc;
    end
    if (bus_if.en != bus_if.key_byte_req) pattern_err++;
    if (int'(bus_if.en) + int'(bus_if.dochoosesboxin) + int'(bus_if.key_reg_move) > 1 ||
        (bus_if.dokeyfirstcol && bus_if.dokeyothercol)) excl_err++;
    if (bus_if.hold && (bus_if.subkey_valid || bus_if.key_reg_move || bus_if.dofirstsubkey ||
        bus_if.dokeyfirstcol || bus_if.dokeyothercol || bus_if.doxorRcon || bus_if.subkey_last))
      hold_err++;
    if (bus_if.sbox_req) begin
      req_cycles++;
      req_run++;
      if (bus_if.en || bus_if.key_reg_move || bus_if.subkey_valid || bus_if.dofirstsubkey ||
          bus_if.dokeyfirstcol || bus_if.dokeyothercol || bus_if.doxorRcon) req_err++;
    end else begin
      req_run = 0;
    end
    if (bus_if.dochoosesboxin) choose_count++;

    if (bus_if.subkey_valid) begin
      r = k / 8;
      c = k % 8;
      if (int'(bus_if.round_idx) != r) pattern_err++;
      if (!bus_if.key_reg_move) pattern_err++;
      if (bus_if.dofirstsubkey != (r == 0)) pattern_err++;
      if (bus_if.dokeyfirstcol != (r > 0 && c < 2)) pattern_err++;
      if (bus_if.dokeyothercol != (r > 0 && c >= 2)) pattern_err++;
      if (bus_if.doxorRcon != (r > 0 && c == 0)) pattern_err++;
      if (bus_if.subkey_last != (r == 10 && c == 7)) pattern_err++;
      if (r > 0 && c == 0) rcon_trace = {rcon_trace[71:0], bus_if.Rcon};
      if (bus_if.subkey_last) last_cycle = cyc;
      if (k == v.hold_after_k) hold_pending = v.hold_len;
      k++;
    end else if (bus_if.doxorRcon || bus_if.dokeyfirstcol || bus_if.dokeyothercol ||
                 bus_if.dofirstsubkey || bus_if.subkey_last) begin
      pattern_err++;
    end

    if (bus_if.done) begin
      done_cycle  = cyc;
      final_rcon  = bus_if.Rcon;
      final_round = int'(bus_if.round_idx);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    en_count = 0; first_en = -1; last_en = -1; k = 0;
    pattern_err = 0; excl_err = 0; hold_err = 0; req_err = 0;
    req_cycles = 0; req_run = 0; choose_count = 0; last_cycle = -1;
    rcon_trace = '0; done_cycle = -1; final_rcon = '0; final_round = -1;
    hold_pending = 0; granted = 1'b0;
    @(posedge clk); #1;
    cyc = 0;
    bus_if.start    = 1'b1;
    bus_if.hold     = 1'b0;
    bus_if.sbox_gnt = (v.gnt_delay == 0);
    while (done_cycle < 0 && cyc < MAX_CYCLES) begin
      @(negedge clk);
      sampleCycle(v);
      if (done_cycle < 0) begin
        @(posedge clk); #1;
        cyc++;
        bus_if.start    = v.stray_start && (cyc == 5 || cyc == 44);
        bus_if.sbox_gnt = (req_run >= v.gnt_delay);
        if (hold_pending > 0) begin
          bus_if.hold = 1'b1;
          hold_pending--;
        end else begin
          bus_if.hold = 1'b0;
        end
      end
    end
    bus_if.start = 1'b0;
    bus_if.hold  = 1'b0;
    @(posedge clk); #1;
    bus_if.sbox_gnt = 1'b0;
    @(negedge clk);
    idle_busy = bus_if.busy;
  endtask

  task automatic runRow(input vec_t v, input string tag);
    applyStimulus(v);
    checkOutput({tag, ".done_cycle"}, done_cycle, v.exp_done_cycle);
    checkOutput({tag, ".en_count"}, en_count, v.exp_en);
    checkOutput({tag, ".first_en"}, first_en, 1);
    checkOutput({tag, ".last_en"}, last_en, v.exp_en);
    checkOutput({tag, ".valid_count"}, k, v.exp_valid);
    checkOutput({tag, ".pattern_err"}, pattern_err, 0);
    checkOutput({tag, ".excl_err"}, excl_err, 0);
    checkOutput({tag, ".hold_err"}, hold_err, 0);
    checkOutput({tag, ".req_err"}, req_err, 0);
    checkOutput({tag, ".req_cycles"}, req_cycles, 10 * (4 + v.gnt_delay));
    checkOutput({tag, ".choose_count"}, choose_count, 10);
    checkOutput({tag, ".last_cycle"}, last_cycle, v.exp_done_cycle - 1);
    checkOutput({tag, ".final_rcon"}, int'(final_rcon), int'(v.exp_final_rcon));
    checkOutput({tag, ".final_round"}, final_round, 10);
    checkOutput({tag, ".idle_busy"}, int'(idle_busy), 0);
    total++;
    if (rcon_trace !== RCON_TRACE) begin
      bad++;
      $display("[TB] FAIL %s.rcon_trace: got %h expected %h", tag, rcon_trace, RCON_TRACE);
    end
  endtask

  // Main sequence: reset, table rows, then reset in the middle of round 6.
  initial begin
    bit found;
    vecs[0] = '{0, -1, 0, 1'b0, 145, 16, 88, 8'h6C};
    vecs[1] = '{5, -1, 0, 1'b0, 195, 16, 88, 8'h6C};
    vecs[2] = '{0, 32, 3, 1'b0, 148, 16, 88, 8'h6C};
    vecs[3] = '{0, -1, 0, 1'b1, 145, 16, 88, 8'h6C};
    vecs[4] = '{1,  3, 2, 1'b0, 157, 16, 88, 8'h6C};

    rst_n           = 1'b0;
    bus_if.start    = 1'b0;
    bus_if.hold     = 1'b0;
    bus_if.sbox_gnt = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset.busy", int'(bus_if.busy), 0);
    checkOutput("reset.rcon", int'(bus_if.Rcon), 'h01);
    checkOutput("reset.round_idx", int'(bus_if.round_idx), 0);
    checkOutput("reset.done", int'(bus_if.done), 0);
    checkOutput("reset.outs", int'(all_outs()), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      $display("[TB] row %0d", i);
      runRow(vecs[i], $sformatf("row%0d", i));
    end

    $display("[TB] reset during round 6 WAIT");
    found = 1'b0;
    @(posedge clk); #1;
    bus_if.start    = 1'b1;
    bus_if.sbox_gnt = 1'b1;
    for (int i = 0; i < MAX_CYCLES && !found; i++) begin
      @(negedge clk);
      if (bus_if.dochoosesboxin && bus_if.round_idx == 4'd6) found = 1'b1;
      @(posedge clk); #1;
      bus_if.start = 1'b0;
    end
    checkOutput("midreset.found_prep", int'(found), 1);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midreset.rcon_before", int'(bus_if.Rcon), 'h20);
    checkOutput("midreset.req_before", int'(bus_if.sbox_req), 1);
    @(posedge clk); #1;
    rst_n           = 1'b1;
    bus_if.sbox_gnt = 1'b0;
    @(negedge clk);
    checkOutput("midreset.busy", int'(bus_if.busy), 0);
    checkOutput("midreset.rcon", int'(bus_if.Rcon), 'h01);
    checkOutput("midreset.round_idx", int'(bus_if.round_idx), 0);
    checkOutput("midreset.done", int'(bus_if.done), 0);
    checkOutput("midreset.outs", int'(all_outs()), 0);
    runRow(vecs[0], "after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
